// File: rtl/ahb_lite_cmd_master_if.sv
// Command port and AHB-Lite manager signals bundled for ahb_lite_cmd_master.
// The modport named master is the view used by the command master.
// The modport named slave is the view used by the controller and the fabric.
// Command port: cmd_valid/cmd_ready handshake carrying cmd_addr, cmd_write, cmd_size and cmd_wdata.
// Response port: the rsp_valid strobe carrying rsp_rdata and rsp_err.
// AHB-Lite port: HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK and HWDATA out; HRDATA, HREADY and HRESP in.
interface ahb_lite_cmd_master_if;
    // command / response side
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    // AHB-Lite side
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_cmd_master.sv
// Single-outstanding AHB-Lite manager: one valid/ready command becomes one NONSEQ SINGLE transfer.
// Latency: a zero-wait transfer responds 2 cycles after accept; a rejected (misaligned/size 3) command responds on the next cycle.
// Backpressure: cmd_ready is high only when idle; HREADY stretches the address and data phases; the response is never stalled.
// Ports:
//   HCLK     bus clock; all logic runs on its rising edge.
//   HRESETn  asynchronous active-low reset.
//   bus      ahb_lite_cmd_master_if.master: command port (cmd_*), response strobe (rsp_*), AHB-Lite manager signals (H*).
module ahb_lite_cmd_master #(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_lite_cmd_master_if.master bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        misaligned;
    logic        capture;
    logic [31:0] wdata_lanes;
    logic [31:0] rd_shift;
    logic [31:0] rd_lane;

    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = HPROT_VAL;
    assign bus.HMASTLOCK = 1'b0;

    assign accept  = (state == ST_IDLE) && bus.cmd_valid;
    assign capture = (state == ST_DATA) && bus.HREADY;

    // Size 3 is never legal; half and word must be naturally aligned.
    always_comb begin
        misaligned = 1'b0;
        case (bus.cmd_size)
            2'd1:    misaligned = bus.cmd_addr[0];
            2'd2:    misaligned = |bus.cmd_addr[1:0];
            2'd3:    misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // Replicate narrow write data across all lanes so the slave sees it whatever the address.
    always_comb begin
        wdata_lanes = bus.cmd_wdata;
        case (bus.cmd_size)
            2'd0:    wdata_lanes = {4{bus.cmd_wdata[7:0]}};
            2'd1:    wdata_lanes = {2{bus.cmd_wdata[15:0]}};
            default: wdata_lanes = bus.cmd_wdata;
        endcase
    end

    // HADDR/HSIZE still hold the command while in DATA, so they select the read lane.
    // The address is aligned, so one byte-granular shift covers both byte and half.
    assign rd_shift = bus.HRDATA >> {bus.HADDR[1:0], 3'b000};

    always_comb begin
        rd_lane = bus.HRDATA;
        case (bus.HSIZE[1:0])
            2'd0:    rd_lane = {24'd0, rd_shift[7:0]};
            2'd1:    rd_lane = {16'd0, rd_shift[15:0]};
            default: rd_lane = bus.HRDATA;
        endcase
    end

    // State register. HTRANS is decoded from the state, so reset returns it to IDLE without waiting for a clock.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.HTRANS    = HTRANS_IDLE;
        case (state)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_nxt = misaligned ? ST_RESP : ST_ADDR;
                end
            end
            ST_ADDR: begin
                bus.HTRANS = HTRANS_NONSEQ;
                if (bus.HREADY) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                // HREADY low covers both wait states and the first cycle of an ERROR response.
                if (bus.HREADY) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                state_nxt     = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address-phase signals load only for commands that actually reach the bus.
    // A rejected command therefore leaves the previous HADDR/HSIZE/HWRITE on the bus.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            bus.HADDR     <= 32'd0;
            bus.HWRITE    <= 1'b0;
            bus.HSIZE     <= 3'd0;
            bus.HWDATA    <= 32'd0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
        end else begin
            if (accept && !misaligned) begin
                bus.HADDR  <= bus.cmd_addr;
                bus.HWRITE <= bus.cmd_write;
                bus.HSIZE  <= {1'b0, bus.cmd_size};
                if (bus.cmd_write) begin
                    bus.HWDATA <= wdata_lanes;
                end
            end

            if (accept && misaligned) begin
                bus.rsp_err   <= 1'b1;
                bus.rsp_rdata <= 32'd0;
            end else if (capture) begin
                bus.rsp_err   <= bus.HRESP;
                bus.rsp_rdata <= (bus.HWRITE || bus.HRESP) ? 32'd0 : rd_lane;
            end else if (state == ST_RESP) begin
                bus.rsp_err   <= 1'b0;
                bus.rsp_rdata <= 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
module tb_ahb_lite_cmd_master;
    logic hclk;
    logic hresetn;
    int   n_cmp;
    int   n_miss;

    ahb_lite_cmd_master_if bus();

    ahb_lite_cmd_master #(.HPROT_VAL(4'b0011)) dut (
        .HCLK    (hclk),
        .HRESETn (hresetn),
        .bus     (bus)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          addr_waits;
        int          data_waits;
        logic        hresp;
        logic [31:0] hrdata;
        logic        reject;
        logic [31:0] exp_hwdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL v%0d.%s: got %h, expected %h", idx, name, act, exp);
        end
    endtask

    task automatic drive_cmd(input logic wr, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_size  = size;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
    endtask

    // Starts and ends on a falling edge; the slave side is driven cycle by cycle from the vector.
    task automatic run_vec(input vec_t v, input int idx);
        logic last;
        chk(idx, "rdy_idle", 32'(bus.cmd_ready), 32'd1);
        drive_cmd(v.wr, v.size, v.addr, v.wdata);
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = 32'hFFFF_FFFF;
        @(negedge hclk);
        bus.cmd_valid = 1'b0;
        if (v.reject) begin
            chk(idx, "rej_htrans", 32'(bus.HTRANS), 32'd0);
            chk(idx, "rej_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk(idx, "rej_rsp_err", 32'(bus.rsp_err), 32'd1);
            chk(idx, "rej_rsp_rdata", bus.rsp_rdata, 32'd0);
            chk(idx, "rej_rdy", 32'(bus.cmd_ready), 32'd0);
            @(negedge hclk);
            chk(idx, "rej_rsp_done", 32'(bus.rsp_valid), 32'd0);
            chk(idx, "rej_htrans2", 32'(bus.HTRANS), 32'd0);
            chk(idx, "rej_rdy2", 32'(bus.cmd_ready), 32'd1);
            return;
        end
        for (int w = 0; w <= v.addr_waits; w++) begin
            chk(idx, "a_htrans", 32'(bus.HTRANS), 32'd2);
            chk(idx, "a_haddr", bus.HADDR, v.addr);
            chk(idx, "a_hwrite", 32'(bus.HWRITE), 32'(v.wr));
            chk(idx, "a_hsize", 32'(bus.HSIZE), 32'({1'b0, v.size}));
            chk(idx, "a_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk(idx, "a_rdy", 32'(bus.cmd_ready), 32'd0);
            bus.HREADY = (w == v.addr_waits);
            @(negedge hclk);
        end
        for (int w = 0; w <= v.data_waits; w++) begin
            last = (w == v.data_waits);
            chk(idx, "d_htrans", 32'(bus.HTRANS), 32'd0);
            chk(idx, "d_haddr", bus.HADDR, v.addr);
            chk(idx, "d_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            if (v.wr) chk(idx, "d_hwdata", bus.HWDATA, v.exp_hwdata);
            bus.HREADY = last;
            // ERROR is two cycles: HREADY low then high, HRESP high in both.
            bus.HRESP  = v.hresp && (w >= v.data_waits - 1);
            bus.HRDATA = last ? v.hrdata : 32'hFFFF_FFFF;
            @(negedge hclk);
        end
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = 32'hFFFF_FFFF;
        chk(idx, "rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk(idx, "rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
        chk(idx, "rsp_rdata", bus.rsp_rdata, v.exp_rdata);
        chk(idx, "r_htrans", 32'(bus.HTRANS), 32'd0);
        chk(idx, "r_rdy", 32'(bus.cmd_ready), 32'd0);
        @(negedge hclk);
        chk(idx, "rsp_done", 32'(bus.rsp_valid), 32'd0);
        chk(idx, "rdy_back", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        vec_t v;
        n_cmp  = 0;
        n_miss = 0;
        //            wr  sz    addr          wdata         aw dw err hrdata        rej exp_hwdata    exp_rdata     err
        vecs[0]  = '{1'b1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 2'd0, 32'h0000_0013, 32'h0,         0, 0, 1'b0, 32'hA1B2_C3D4, 1'b0, 32'h0,         32'h0000_00A1, 1'b0};
        vecs[2]  = '{1'b1, 2'd1, 32'h0000_0006, 32'h0000_1234, 0, 3, 1'b0, 32'hCAFE_F00D, 1'b0, 32'h1234_1234, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 2'd2, 32'h0000_0020, 32'h0,         0, 1, 1'b1, 32'h55AA_55AA, 1'b0, 32'h0,         32'h0,         1'b1};
        vecs[4]  = '{1'b0, 2'd2, 32'h0000_0002, 32'h0,         0, 0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h0,         1'b1};
        vecs[5]  = '{1'b0, 2'd3, 32'h0000_0000, 32'h0,         0, 0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h0,         1'b1};
        vecs[6]  = '{1'b0, 2'd1, 32'h0000_0002, 32'h0,         0, 0, 1'b0, 32'hA1B2_C3D4, 1'b0, 32'h0,         32'h0000_A1B2, 1'b0};
        vecs[7]  = '{1'b0, 2'd1, 32'h0000_0000, 32'h0,         0, 0, 1'b0, 32'hA1B2_C3D4, 1'b0, 32'h0,         32'h0000_C3D4, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 32'h0000_0011, 32'h0,         0, 0, 1'b0, 32'hA1B2_C3D4, 1'b0, 32'h0,         32'h0000_00C3, 1'b0};
        vecs[9]  = '{1'b0, 2'd0, 32'h0000_0010, 32'h0,         0, 0, 1'b0, 32'hA1B2_C3D4, 1'b0, 32'h0,         32'h0000_00D4, 1'b0};
        vecs[10] = '{1'b1, 2'd0, 32'h0000_0041, 32'h1234_56A5, 0, 0, 1'b0, 32'hCAFE_F00D, 1'b0, 32'hA5A5_A5A5, 32'h0,         1'b0};
        vecs[11] = '{1'b0, 2'd2, 32'h0000_0100, 32'h0,         2, 1, 1'b0, 32'h0BAD_F00D, 1'b0, 32'h0,         32'h0BAD_F00D, 1'b0};
        vecs[12] = '{1'b0, 2'd1, 32'h0000_0005, 32'h0,         0, 0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h0,         1'b1};
        vecs[13] = '{1'b1, 2'd2, 32'h0000_0030, 32'h1122_3344, 0, 2, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h1122_3344, 32'h0,         1'b1};
        vecs[14] = '{1'b1, 2'd1, 32'h0000_000A, 32'hABCD_5678, 1, 0, 1'b0, 32'hCAFE_F00D, 1'b0, 32'h5678_5678, 32'h0,         1'b0};

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_size  = 2'd0;
        bus.cmd_addr  = 32'd0;
        bus.cmd_wdata = 32'd0;
        bus.HRDATA    = 32'd0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;
        hresetn       = 1'b1;
        #1 hresetn = 1'b0;
        #2;
        chk(90, "rst_rdy", 32'(bus.cmd_ready), 32'd1);
        chk(90, "rst_htrans", 32'(bus.HTRANS), 32'd0);
        chk(90, "rst_haddr", bus.HADDR, 32'd0);
        chk(90, "rst_hwrite", 32'(bus.HWRITE), 32'd0);
        chk(90, "rst_hsize", 32'(bus.HSIZE), 32'd0);
        chk(90, "rst_hwdata", bus.HWDATA, 32'd0);
        chk(90, "rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk(90, "rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk(90, "rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk(90, "hburst", 32'(bus.HBURST), 32'd0);
        chk(90, "hprot", 32'(bus.HPROT), 32'h3);
        chk(90, "hmastlock", 32'(bus.HMASTLOCK), 32'd0);
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
        @(negedge hclk);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset while the address phase is stalled: HTRANS must drop before any clock edge.
        drive_cmd(1'b0, 2'd2, 32'h0000_0044, 32'd0);
        @(negedge hclk);
        bus.cmd_valid = 1'b0;
        bus.HREADY    = 1'b0;
        chk(100, "pre_htrans", 32'(bus.HTRANS), 32'd2);
        #1 hresetn = 1'b0;
        #1;
        chk(100, "async_htrans", 32'(bus.HTRANS), 32'd0);
        chk(100, "async_haddr", bus.HADDR, 32'd0);
        chk(100, "async_rdy", 32'(bus.cmd_ready), 32'd1);
        bus.HREADY = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge hclk);
            chk(100, "no_rsp", 32'(bus.rsp_valid), 32'd0);
            chk(100, "idle_htrans", 32'(bus.HTRANS), 32'd0);
        end
        hresetn = 1'b1;
        @(negedge hclk);
        chk(100, "rdy_after", 32'(bus.cmd_ready), 32'd1);

        // Reset in the middle of a stalled write data phase: the command is dropped silently.
        drive_cmd(1'b1, 2'd2, 32'h0000_0048, 32'h8765_4321);
        @(negedge hclk);
        bus.cmd_valid = 1'b0;
        bus.HREADY    = 1'b1;
        @(negedge hclk);
        bus.HREADY = 1'b0;
        chk(101, "data_htrans", 32'(bus.HTRANS), 32'd0);
        chk(101, "data_hwdata", bus.HWDATA, 32'h8765_4321);
        @(negedge hclk);
        chk(101, "data_hold", bus.HWDATA, 32'h8765_4321);
        chk(101, "data_rdy", 32'(bus.cmd_ready), 32'd0);
        #1 hresetn = 1'b0;
        #1;
        chk(101, "async_hwdata", bus.HWDATA, 32'd0);
        chk(101, "async_htrans", 32'(bus.HTRANS), 32'd0);
        bus.HREADY = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge hclk);
            chk(101, "no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        hresetn = 1'b1;
        @(negedge hclk);
        chk(101, "rdy_after", 32'(bus.cmd_ready), 32'd1);
        v = '{1'b0, 2'd2, 32'h0000_0048, 32'h0, 0, 0, 1'b0, 32'h1357_9BDF, 1'b0, 32'h0, 32'h1357_9BDF, 1'b0};
        run_vec(v, 102);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end
endmodule
